if_fetch: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core. It drives the instruction-memory request/response interface and buffers returned words in a small prefetch FIFO. Each cycle it presents one instruction (or a NOP bubble) to the decode stage via IF_Instr/IF_Pc/IF_Pc4/NopIFInstr. It is the consumer of decode's replay interface (StallPc/Pc_update/Stalled_Instr) and of the branch redirect.

---
 rtl/if_fetch.sv | 226 ++++++++++++++++++++++
 tb/tb_if_fetch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage of the pipelined RISC-V core.
// Issues word-aligned requests to instruction memory and buffers the returned
// words in a small prefetch FIFO. Each cycle it hands decode either one
// instruction or a NOP bubble. It also services decode's load-use replay and
// the branch redirect.
// Optional feature: define IF_MISALIGN_CHECK_EN to add the Fetch_Misalign
// fault output. A misaligned redirect then halts fetch permanently. When the
// macro is undefined, the low two bits of the redirect target are ignored.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Pc,
    input  logic        StallPc,
    input  logic [31:0] Pc_update,
    input  logic [31:0] Stalled_Instr,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_Pc,
    output logic [31:0] IF_Pc4,
    output logic        NopIFInstr
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        Fetch_Misalign
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    // Fetch-side state
    logic [31:0]      fpc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] out_next;
    logic [CNT_W-1:0] drop_cnt;

    // Prefetch FIFO
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    // Replay slot and output register
    logic             replay_valid;
    logic [31:0]      replay_instr;
    logic [31:0]      replay_pc;
    logic [31:0]      out_instr;
    logic [31:0]      out_pc;
    logic [31:0]      out_pc4;
    logic             out_bubble;

    logic [31:0]      redirect_target;
    logic             fetch_halted;
    logic             grant;
    logic             rsp_fire;
    logic             rsp_keep;
    logic             pop;
    logic [CNT_W:0]   occupancy;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q;

    assign redirect_target = Redirect_Pc;
    assign fetch_halted    = misalign_q;
    assign Fetch_Misalign  = misalign_q;

    // A redirect to a non-word-aligned target latches a sticky fault until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (Redirect && (Redirect_Pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end
`else
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^Redirect_Pc[1:0];
    assign redirect_target      = {Redirect_Pc[31:2], 2'b00};
    assign fetch_halted         = 1'b0;
`endif

    // The output register consumes a FIFO word only when nothing higher-priority claims the slot.
    assign pop = !Redirect && !StallPc && !replay_valid && !fetch_halted &&
                 (fifo_count != '0);

    // A word popped this cycle frees its FIFO entry. This keeps a depth-2
    // FIFO streaming at one word per cycle.
    assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop};

    assign imem_req  = !rst && !Redirect && !fetch_halted && (occupancy < DEPTH_LIMIT);
    assign imem_addr = fpc;
    assign grant     = imem_req && imem_gnt;

    // A response that arrives while nothing is outstanding is stale (for example, after reset) and is ignored.
    assign rsp_fire = imem_rvalid && (outstanding != '0);
    assign rsp_keep = rsp_fire && !Redirect && (drop_cnt == '0);

    // Outstanding count after this cycle's request and response
    always_comb begin
        out_next = outstanding;
        if (grant && !rsp_fire) begin
            out_next = outstanding + CNT_W'(1);
        end else if (!grant && rsp_fire) begin
            out_next = outstanding - CNT_W'(1);
        end
    end

    // Track fetch PC, in-flight requests, words to discard and the PC of the next kept response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc         <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_next;
            if (Redirect) begin
                fpc      <= redirect_target;
                rsp_pc   <= redirect_target;
                drop_cnt <= out_next;
            end else begin
                if (grant) begin
                    fpc <= fpc + 32'd4;
                end
                if (rsp_fire && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
            end
        end
    end

    // Write kept response words and their PCs into the FIFO storage
    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= rsp_pc;
        end
    end

    // Maintain FIFO pointers and occupancy; a redirect flushes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (Redirect) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (rsp_keep) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (rsp_keep && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!rsp_keep && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    // Choose what decode sees next: redirect bubble, replay, parked word, FIFO word, or bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_instr    <= NOP_INSTR;
            out_pc       <= RESET_PC;
            out_pc4      <= RESET_PC + 32'd4;
            out_bubble   <= 1'b1;
            replay_valid <= 1'b0;
            replay_instr <= NOP_INSTR;
            replay_pc    <= RESET_PC;
        end else if (Redirect || fetch_halted) begin
            replay_valid <= 1'b0;
            out_instr    <= NOP_INSTR;
            out_bubble   <= 1'b1;
        end else if (StallPc) begin
            out_instr  <= Stalled_Instr;
            out_pc     <= Pc_update;
            out_pc4    <= Pc_update + 32'd4;
            out_bubble <= 1'b0;
            if (!out_bubble) begin
                replay_valid <= 1'b1;
                replay_instr <= out_instr;
                replay_pc    <= out_pc;
            end
        end else if (replay_valid) begin
            out_instr    <= replay_instr;
            out_pc       <= replay_pc;
            out_pc4      <= replay_pc + 32'd4;
            out_bubble   <= 1'b0;
            replay_valid <= 1'b0;
        end else if (pop) begin
            out_instr  <= fifo_instr[rd_ptr];
            out_pc     <= fifo_pc[rd_ptr];
            out_pc4    <= fifo_pc[rd_ptr] + 32'd4;
            out_bubble <= 1'b0;
        end else begin
            out_instr  <= NOP_INSTR;
            out_bubble <= 1'b1;
        end
    end

    assign IF_Instr   = out_instr;
    assign IF_Pc      = out_pc;
    assign IF_Pc4     = out_pc4;
    assign NopIFInstr = out_bubble | StallPc;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed testbench for the if_fetch instruction-fetch stage.
// The memory model grants on request and returns words in order after
// mem_lat cycles. Each word is word_at(addr), so a word's origin can be
// identified at the decode side.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        Redirect;
    logic [31:0] Redirect_Pc;
    logic        StallPc;
    logic [31:0] Pc_update;
    logic [31:0] Stalled_Instr;
    logic [31:0] IF_Instr;
    logic [31:0] IF_Pc;
    logic [31:0] IF_Pc4;
    logic        NopIFInstr;
`ifdef IF_MISALIGN_CHECK_EN
    logic        Fetch_Misalign;
`endif

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int cyc = 0;
    logic [31:0] addr_q[$];
    int          due_q[$];

    if_fetch dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .Redirect(Redirect),
        .Redirect_Pc(Redirect_Pc),
        .StallPc(StallPc),
        .Pc_update(Pc_update),
        .Stalled_Instr(Stalled_Instr),
        .IF_Instr(IF_Instr),
        .IF_Pc(IF_Pc),
        .IF_Pc4(IF_Pc4),
        .NopIFInstr(NopIFInstr)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .Fetch_Misalign(Fetch_Misalign)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA000_0000 ^ a;
    endfunction

    // Capture granted requests mid-cycle, when the request signals are stable
    always @(negedge clk) begin
        if (imem_req && imem_gnt) begin
            addr_q.push_back(imem_addr);
            due_q.push_back(cyc + mem_lat);
        end
    end

    // Return responses in order once their latency has elapsed
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_at(addr_q.pop_front());
            void'(due_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit clear_mem);
        rst = 1'b1;
        Redirect = 1'b0;
        StallPc = 1'b0;
        if (clear_mem) begin
            addr_q.delete();
            due_q.delete();
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_gnt = 1'b1;
        step();
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (IF_Instr !== NOP) begin errors++; $display("[TB] FAIL reset_instr: got %h expected %h", IF_Instr, NOP); end
        checks++; if (IF_Pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", IF_Pc); end
        checks++; if (IF_Pc4 !== 32'h4) begin errors++; $display("[TB] FAIL reset_pc4: got %h expected 4", IF_Pc4); end
        checks++; if (NopIFInstr !== 1'b1) begin errors++; $display("[TB] FAIL reset_nop: got %b expected 1", NopIFInstr); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_first_req: got req %b addr %h expected 1 0", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        bit          exp_bub [6];
        logic [31:0] exp_pc  [6];
        exp_bub = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_pc  = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
        mem_lat = 1;
        imem_gnt = 1'b1;
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (NopIFInstr !== exp_bub[i]) begin errors++; $display("[TB] FAIL stream_nop[%0d]: got %b expected %b", i, NopIFInstr, exp_bub[i]); end
            checks++; if (IF_Pc !== exp_pc[i]) begin errors++; $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", i, IF_Pc, exp_pc[i]); end
            if (!exp_bub[i]) begin
                checks++; if (IF_Instr !== word_at(exp_pc[i])) begin errors++; $display("[TB] FAIL stream_instr[%0d]: got %h expected %h", i, IF_Instr, word_at(exp_pc[i])); end
                checks++; if (IF_Pc4 !== exp_pc[i] + 32'd4) begin errors++; $display("[TB] FAIL stream_pc4[%0d]: got %h expected %h", i, IF_Pc4, exp_pc[i] + 32'd4); end
            end else begin
                checks++; if (IF_Instr !== NOP) begin errors++; $display("[TB] FAIL stream_bubble_instr[%0d]: got %h expected %h", i, IF_Instr, NOP); end
            end
        end
    endtask

    task automatic test_gnt_hold();
        mem_lat = 1;
        imem_gnt = 1'b0;
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (NopIFInstr !== 1'b1) begin errors++; $display("[TB] FAIL hold_nop[%0d]: got %b expected 1", i, NopIFInstr); end
            checks++; if (IF_Pc !== 32'h0) begin errors++; $display("[TB] FAIL hold_pc[%0d]: got %h expected 0", i, IF_Pc); end
            checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL hold_addr[%0d]: got %h expected 0", i, imem_addr); end
        end
        imem_gnt = 1'b1;
        step();
        step();
        step();
        checks++; if (NopIFInstr !== 1'b0 || IF_Pc !== 32'h0) begin errors++; $display("[TB] FAIL hold_resume: got nop %b pc %h expected 0 0", NopIFInstr, IF_Pc); end
    endtask

    task automatic test_redirect();
        int seen = 0;
        mem_lat = 3;
        imem_gnt = 1'b1;
        do_reset(1'b1);
        step();
        step();
        Redirect = 1'b1;
        Redirect_Pc = 32'h100;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_req: got %b expected 0", imem_req); end
        step();
        Redirect = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 100", imem_addr); end
        checks++; if (NopIFInstr !== 1'b1) begin errors++; $display("[TB] FAIL redir_bubble: got %b expected 1", NopIFInstr); end
        for (int i = 0; i < 40 && seen < 3; i++) begin
            step();
            if (!NopIFInstr) begin
                checks++; if (IF_Pc !== 32'h100 + 32'(4 * seen)) begin errors++; $display("[TB] FAIL redir_pc[%0d]: got %h expected %h", seen, IF_Pc, 32'h100 + 32'(4 * seen)); end
                checks++; if (IF_Instr !== word_at(32'h100 + 32'(4 * seen))) begin errors++; $display("[TB] FAIL redir_instr[%0d]: got %h expected %h", seen, IF_Instr, word_at(32'h100 + 32'(4 * seen))); end
                seen++;
            end
        end
        checks++; if (seen != 3) begin errors++; $display("[TB] FAIL redir_timeout: got %0d words expected 3", seen); end
        mem_lat = 1;
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h10, 32'h14, 32'h18, 32'h1C};
        mem_lat = 1;
        imem_gnt = 1'b1;
        do_reset(1'b1);
        repeat (8) step();
        checks++; if (IF_Pc !== 32'h14 || NopIFInstr !== 1'b0) begin errors++; $display("[TB] FAIL stall_pre: got pc %h nop %b expected 14 0", IF_Pc, NopIFInstr); end
        StallPc = 1'b1;
        Pc_update = 32'h10;
        Stalled_Instr = word_at(32'h10);
        #1;
        checks++; if (NopIFInstr !== 1'b1) begin errors++; $display("[TB] FAIL stall_kill: got %b expected 1", NopIFInstr); end
        step();
        StallPc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            #1;
            checks++; if (NopIFInstr !== 1'b0) begin errors++; $display("[TB] FAIL stall_nop[%0d]: got %b expected 0", i, NopIFInstr); end
            checks++; if (IF_Pc !== exp_pc[i]) begin errors++; $display("[TB] FAIL stall_pc[%0d]: got %h expected %h", i, IF_Pc, exp_pc[i]); end
            checks++; if (IF_Instr !== word_at(exp_pc[i])) begin errors++; $display("[TB] FAIL stall_instr[%0d]: got %h expected %h", i, IF_Instr, word_at(exp_pc[i])); end
        end
    endtask

    task automatic test_redirect_stall();
        mem_lat = 1;
        imem_gnt = 1'b1;
        do_reset(1'b1);
        repeat (5) step();
        Redirect = 1'b1;
        Redirect_Pc = 32'h200;
        StallPc = 1'b1;
        Pc_update = 32'h40;
        Stalled_Instr = 32'hDEAD_BEEF;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rs_req: got %b expected 0", imem_req); end
        step();
        Redirect = 1'b0;
        StallPc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            #1;
            if (i < 3) begin
                checks++; if (NopIFInstr !== 1'b1 || IF_Instr !== NOP) begin errors++; $display("[TB] FAIL rs_bubble[%0d]: got nop %b instr %h expected 1 %h", i, NopIFInstr, IF_Instr, NOP); end
            end else begin
                checks++; if (NopIFInstr !== 1'b0) begin errors++; $display("[TB] FAIL rs_nop[%0d]: got %b expected 0", i, NopIFInstr); end
                checks++; if (IF_Pc !== 32'h200 + 32'(4 * (i - 3))) begin errors++; $display("[TB] FAIL rs_pc[%0d]: got %h expected %h", i, IF_Pc, 32'h200 + 32'(4 * (i - 3))); end
                checks++; if (IF_Instr !== word_at(32'h200 + 32'(4 * (i - 3)))) begin errors++; $display("[TB] FAIL rs_instr[%0d]: got %h expected %h", i, IF_Instr, word_at(32'h200 + 32'(4 * (i - 3)))); end
            end
        end
    endtask

    task automatic test_misalign();
        mem_lat = 1;
        imem_gnt = 1'b1;
        do_reset(1'b1);
        repeat (4) step();
        Redirect = 1'b1;
        Redirect_Pc = 32'h102;
        step();
        Redirect = 1'b0;
        #1;
`ifdef IF_MISALIGN_CHECK_EN
        checks++; if (Fetch_Misalign !== 1'b1) begin errors++; $display("[TB] FAIL mis_flag: got %b expected 1", Fetch_Misalign); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (imem_req !== 1'b0 || NopIFInstr !== 1'b1) begin errors++; $display("[TB] FAIL mis_halt[%0d]: got req %b nop %b expected 0 1", i, imem_req, NopIFInstr); end
            step();
        end
`else
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL mis_addr: got %h expected 100", imem_addr); end
        step();
        step();
        step();
        checks++; if (NopIFInstr !== 1'b0 || IF_Pc !== 32'h100) begin errors++; $display("[TB] FAIL mis_pc: got nop %b pc %h expected 0 100", NopIFInstr, IF_Pc); end
        checks++; if (IF_Instr !== word_at(32'h100)) begin errors++; $display("[TB] FAIL mis_instr: got %h expected %h", IF_Instr, word_at(32'h100)); end
`endif
    endtask

    task automatic test_reset_midburst();
        mem_lat = 3;
        imem_gnt = 1'b1;
        do_reset(1'b1);
        step();
        step();
        rst = 1'b1;
        imem_gnt = 1'b0;
        #1;
        checks++; if (IF_Instr !== NOP || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset: got instr %h req %b expected %h 0", IF_Instr, imem_req, NOP); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (NopIFInstr !== 1'b1) begin errors++; $display("[TB] FAIL mid_stale[%0d]: got nop %b pc %h expected bubble", i, NopIFInstr, IF_Pc); end
        end
        mem_lat = 1;
        imem_gnt = 1'b1;
        step();
        step();
        step();
        checks++; if (NopIFInstr !== 1'b0 || IF_Pc !== 32'h0 || IF_Instr !== word_at(32'h0)) begin errors++; $display("[TB] FAIL mid_restart: got nop %b pc %h instr %h expected 0 0 %h", NopIFInstr, IF_Pc, IF_Instr, word_at(32'h0)); end
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        Redirect = 1'b0;
        Redirect_Pc = 32'h0;
        StallPc = 1'b0;
        Pc_update = 32'h0;
        Stalled_Instr = 32'h0;
        test_reset();
        test_stream();
        test_gnt_hold();
        test_redirect();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
